// File: rtl/reg_scan_ctrl.sv
// reg_scan_ctrl: walks a register readout mux and streams each captured word
// out over a valid/ready handshake. It can run a full scan of the mapped
// addresses or a single read of any 6-bit address.
// Build option: define SCAN_INTERNAL_EN to include the internal group
// 0x10..0x14 in the full scan (23 words). Without it the scan is 18 words.
module reg_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [5:0]  single_addr,
    input  logic        abort,
    input  logic [15:0] reg_data,
    output logic [1:0]  sel,
    output logic [3:0]  reg_sel,
    output logic [15:0] dout,
    output logic [5:0]  dout_addr,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [5:0] LAST_ADDR  = 6'h3F;

    logic [2:0]  state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic        mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  reg_sel_q, reg_sel_d;
    logic [15:0] dout_q, dout_d;
    logic [5:0]  dout_addr_q, dout_addr_d;
    logic        dout_valid_q, dout_valid_d;

    // Full-scan successor: jumps over the unmapped holes in the address map.
    function automatic logic [5:0] next_scan_addr(input logic [5:0] a);
        logic [5:0] n;
        n = a + 6'd1;
`ifdef SCAN_INTERNAL_EN
        if (a == 6'h14) begin
            n = 6'h3E;
        end
`else
        if (a == 6'h0F) begin
            n = 6'h3E;
        end
`endif
        return n;
    endfunction

    // Next-state and datapath decode; abort overrides everything outside IDLE.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        reg_sel_d    = reg_sel_q;
        dout_d       = dout_q;
        dout_addr_d  = dout_addr_q;
        dout_valid_d = dout_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    mode_d  = mode;
                    addr_d  = mode ? single_addr : 6'h00;
                end
            end
            ST_SETUP: begin
                sel_d     = addr_q[5:4];
                reg_sel_d = addr_q[3:0];
                cnt_d     = SETTLE_CNT;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A zero count is treated like one so the FSM can never stall here.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                dout_d       = reg_data;
                dout_addr_d  = {sel_q, reg_sel_q};
                dout_valid_d = 1'b1;
                state_d      = ST_SEND;
            end
            ST_SEND: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    if (mode_q || (addr_q == LAST_ADDR)) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = next_scan_addr(addr_q);
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                dout_valid_d = 1'b0;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            dout_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 6'h00;
            mode_q       <= 1'b0;
            cnt_q        <= 4'd0;
            sel_q        <= 2'd0;
            reg_sel_q    <= 4'd0;
            dout_q       <= 16'h0000;
            dout_addr_q  <= 6'h00;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            reg_sel_q    <= reg_sel_d;
            dout_q       <= dout_d;
            dout_addr_q  <= dout_addr_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign sel        = sel_q;
    assign reg_sel    = reg_sel_q;
    assign dout       = dout_q;
    assign dout_addr  = dout_addr_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_scan_ctrl.sv
// Testbench for reg_scan_ctrl: single reads from a vector table plus
// hand-written full-scan, abort, reset and start-while-busy sequences.
module tb_reg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [5:0]  single_addr = 6'h00;
    logic        abort = 1'b0;
    logic [15:0] reg_data;
    logic [1:0]  sel;
    logic [3:0]  reg_sel;
    logic [15:0] dout;
    logic [5:0]  dout_addr;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    localparam logic [15:0] PC_VAL = 16'h1234;

    reg_scan_ctrl #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .single_addr(single_addr), .abort(abort), .reg_data(reg_data),
        .sel(sel), .reg_sel(reg_sel), .dout(dout), .dout_addr(dout_addr),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model readout mux: mapped groups return a pattern, 0x3E is the pc, unmapped read 0.
    function automatic logic [15:0] mux_model(input logic [5:0] a);
        logic [15:0] v;
        if (a == 6'h3E)       v = PC_VAL;
        else if (a == 6'h3F)  v = 16'hBEEF;
        else if (a <= 6'h14)  v = 16'hC000 | (16'(a) * 16'h0103);
        else                  v = 16'h0000;
        return v;
    endfunction

    assign reg_data = mux_model({sel, reg_sel});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk(nm, {16'h0, sel, reg_sel, dout_valid, busy, done, 1'b0}, 32'h0);
        chk({nm, "_data"}, {10'h0, dout, dout_addr}, 32'h0);
    endtask

    // One single read; optional extra start while busy and a held-off ready.
    task automatic single_read(input logic [5:0] a, input logic [15:0] exp,
                               input bit poke, input int hold);
        int cyc;
        logic [21:0] snap;
        mode = 1'b1; single_addr = a; start = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0; single_addr = 6'h05;
        cyc = 0;
        if (poke) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            cyc = 1;
        end
        while (!dout_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd3);
        chk("sr_dout", {16'h0, dout}, {16'h0, exp});
        chk("sr_addr", {26'h0, dout_addr}, {26'h0, a});
        snap = {dout_addr, dout};
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_stable", {9'h0, dout_valid, snap}, {9'h0, 1'b1, a, exp});
        end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("sr_done_pulse", {30'h0, done, dout_valid}, {30'h0, 1'b1, 1'b0});
        tick();
        chk("sr_idle_after", {30'h0, done, busy}, 32'h0);
    endtask

    // Full scan with ready held high; abort_at >= 0 aborts on that word's handshake.
    task automatic run_full(input int abort_at);
        logic [5:0] exp_q[$];
        int n, dones, cyc;
        bit fin;
        for (int i = 0; i < 16; i++) exp_q.push_back(6'(i));
`ifdef SCAN_INTERNAL_EN
        for (int i = 16; i < 21; i++) exp_q.push_back(6'(i));
`endif
        exp_q.push_back(6'h3E);
        exp_q.push_back(6'h3F);
        n = 0; dones = 0; cyc = 0; fin = 1'b0;
        mode = 1'b0; dout_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (!fin && cyc < 2000) begin
            if (dout_valid) begin
                if (n < exp_q.size()) begin
                    chk("scan_addr", {26'h0, dout_addr}, {26'h0, exp_q[n]});
                    chk("scan_data", {16'h0, dout}, {16'h0, mux_model(exp_q[n])});
                end else begin
                    chk("scan_extra_word", {26'h0, dout_addr}, 32'hFFFF_FFFF);
                end
                if (n == abort_at) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk("abort_idle", {30'h0, busy, dout_valid}, 32'h0);
                    for (int k = 0; k < 6; k++) begin
                        tick();
                        chk("abort_quiet", {29'h0, busy, dout_valid, done}, 32'h0);
                    end
                    dout_ready = 1'b0;
                    return;
                end
                n++;
            end
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            tick();
            cyc++;
        end
        dout_ready = 1'b0;
        chk("scan_finished", {31'h0, fin}, 32'd1);
        chk("scan_word_count", 32'(n), 32'(exp_q.size()));
        chk("scan_done_count", 32'(dones), 32'd1);
        chk("scan_done_one_cycle", {30'h0, done, busy}, 32'h0);
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] exp_data;
        bit          poke;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{addr: 6'h00, exp_data: 16'hC000, poke: 1'b0, hold: 0};
        vecs[1] = '{addr: 6'h0F, exp_data: 16'hCF2D, poke: 1'b0, hold: 1};
        vecs[2] = '{addr: 6'h13, exp_data: 16'hD339, poke: 1'b0, hold: 0};
        vecs[3] = '{addr: 6'h20, exp_data: 16'h0000, poke: 1'b1, hold: 0};
        vecs[4] = '{addr: 6'h3E, exp_data: 16'h1234, poke: 1'b0, hold: 5};
        vecs[5] = '{addr: 6'h3F, exp_data: 16'hBEEF, poke: 1'b1, hold: 2};
        vecs[6] = '{addr: 6'h2A, exp_data: 16'h0000, poke: 1'b0, hold: 0};

        // Power-on reset
        rst_n = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset_state");
        rst_n = 1'b1;
        tick();
        chk_idle_outputs("idle_after_reset");

        // Single reads from the table
        for (int i = 0; i < 7; i++) begin
            single_read(vecs[i].addr, vecs[i].exp_data, vecs[i].poke, vecs[i].hold);
        end

        // Full scan
        run_full(-1);
        tick();

        // Abort on the handshake of word 0x05, then a clean restart from 0x00
        run_full(5);
        tick();
        run_full(-1);
        tick();

        // Abort while settling
        mode = 1'b1; single_addr = 6'h02; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_wait_idle", {30'h0, busy, dout_valid}, 32'h0);

        // Reset held two cycles while a word waits in SEND
        mode = 1'b1; single_addr = 6'h3E; start = 1'b1; dout_ready = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("send_before_reset", {31'h0, dout_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk_idle_outputs("reset_in_send_1");
        tick();
        chk_idle_outputs("reset_in_send_2");
        rst_n = 1'b1;
        dout_ready = 1'b1;
        tick();
        chk_idle_outputs("after_reset_release");
        dout_ready = 1'b0;

        // Scanner works normally after the mid-operation reset
        single_read(6'h0A, 16'hCA1E, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_scan_ctrl.md
REG_SCAN_CTRL -- requirements
Module: reg_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, number of wait cycles (1..15) between driving a selector address and capturing reg_data.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
REQ-004 start  input  1  begin a scan; sampled only in IDLE.
REQ-005 mode  input  1  0 = full scan, 1 = single read.
REQ-006 single_addr  input  6  {sel, reg_sel} target for single read.
REQ-007 abort  input  1  terminate the current operation.
REQ-008 reg_data  input  16  data returned by the register readout mux.
REQ-009 sel  output  2  selector group driven to the readout mux.
REQ-010 reg_sel  output  4  selector index driven to the readout mux.
REQ-011 dout  output  16  captured word.
REQ-012 dout_addr  output  6  {sel, reg_sel} the dout word was captured from.
REQ-013 dout_valid  output  1  dout/dout_addr valid; held until accepted.
REQ-014 dout_ready  input  1  consumer accepts the word when dout_valid=1 and dout_ready=1 on the same clk edge.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 FSM states: IDLE, SETUP, WAIT, CAPTURE, SEND, DONE.
REQ-018 IDLE->SETUP when start=1; mode and single_addr are latched on that edge; start in any other state is ignored.
REQ-019 SETUP drives sel/reg_sel from the current address, loads the settle counter with SETTLE, and goes to WAIT.
REQ-020 WAIT decrements the counter each cycle and goes to CAPTURE when the count reaches 0; sel/reg_sel stay stable throughout.
REQ-021 CAPTURE registers reg_data into dout and the address into dout_addr, then goes to SEND.
REQ-022 SEND holds dout_valid=1 with dout/dout_addr stable until the handshake completes.
REQ-023 On the handshake edge, SEND goes to DONE if the address was the last in the sequence, or a single read; otherwise it advances the address and goes to SETUP.
REQ-024 DONE asserts done=1 for exactly one cycle, then goes to IDLE.
REQ-025 Full-scan order: 0x00..0x0F (sel=00), 0x10..0x14 (sel=01), 0x3E, 0x3F (sel=11); 23 words in total.
REQ-026 Single reads accept any 6-bit address, including unmapped ones; the captured word is whatever reg_data returns (0 for unmapped addresses).
REQ-027 abort=1 in any non-IDLE state forces IDLE on the next edge; dout_valid drops and no done pulse is produced.
REQ-028 When abort coincides with a SEND handshake, the word counts as transferred and abort still wins: next state is IDLE, no done pulse.
REQ-029 Minimum per-word latency from SETUP to dout_valid is SETTLE+2 cycles.

Reset
REQ-030 While rst_n=0 at a clk edge, the FSM goes to IDLE and sel, reg_sel, dout, dout_addr, dout_valid, busy and done are all 0; the settle counter and latched mode/address are also cleared.
REQ-031 Reset mid-operation abandons the operation immediately, with no done pulse and no held word.

Configuration
REQ-032 Macro SCAN_INTERNAL_EN defined: the full scan includes 0x10..0x14 (23 words).
REQ-033 Macro SCAN_INTERNAL_EN undefined: the full scan skips 0x10..0x14, giving 0x00..0x0F, 0x3E, 0x3F (18 words); single reads are unaffected.

Verification
REQ-034 Reset with rst_n=0 for 2 cycles during SEND -> all outputs 0 and busy=0 on the next cycle, with no done pulse.
REQ-035 Full scan with SCAN_INTERNAL_EN defined, dout_ready=1, SETTLE=1 -> 23 words at addresses 0x00..0x0F, 0x10..0x14, 0x3E, 0x3F, each dout matching the model mux, then one done pulse.
REQ-036 Single read of 0x3E with pc=0x1234 and dout_ready held 0 for 5 cycles -> dout=0x1234 and dout_addr=0x3E held stable the whole time; acceptance is followed by done.
REQ-037 Full scan with SCAN_INTERNAL_EN undefined -> exactly 18 words, the 17th at 0x3E, and no word at 0x10..0x14.
REQ-038 abort asserted together with the handshake of word 0x05 -> IDLE next cycle, no further words, no done; a later start restarts the scan at 0x00.
REQ-039 start pulsed while busy, and single read of 0x20 -> the extra start is ignored; the single read returns dout=0x0000 at dout_addr=0x20.
